regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump.sv | 166 ++++++++++++++++
 tb/tb_regfile_dump.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks a register file through its combinational read port
// and streams every register out as a valid/ready beat, one word per two
// cycles when the consumer never stalls.
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append one extra beat
// carrying the XOR of all dumped words (out_addr=0, out_last=1).
module regfile_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // With a checksum beat following, the last register is never the final beat.
    localparam logic LAST_ON_REG = 1'b0;
`else
    localparam logic LAST_ON_REG = 1'b1;
`endif

    state_t        state_r;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] ra_r;
    logic [DW-1:0] out_data_r;
    logic [AW-1:0] out_addr_r;
    logic          out_valid_r;
    logic          out_last_r;
    logic          busy_r;
    logic          done_r;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DW-1:0] csum_r;
`endif

    assign ra        = ra_r;
    assign out_data  = out_data_r;
    assign out_addr  = out_addr_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Dump sequencer: every output is a register updated together with the state,
    // so ra/busy/done are set on the edge that enters the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {AW{1'b0}};
            ra_r        <= {AW{1'b0}};
            out_data_r  <= {DW{1'b0}};
            out_addr_r  <= {AW{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_r      <= {DW{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        addr_r  <= {AW{1'b0}};
                        ra_r    <= {AW{1'b0}};
                        busy_r  <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum_r  <= {DW{1'b0}};
`endif
                        state_r <= ST_READ;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // rd is combinational from ra, which holds addr_r in this state.
                    out_data_r  <= rd;
                    out_addr_r  <= addr_r;
                    out_valid_r <= 1'b1;
                    out_last_r  <= LAST_ON_REG & (addr_r == LAST_ADDR);
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_r      <= csum_r ^ rd;
`endif
                    ra_r        <= {AW{1'b0}};
                    state_r     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (addr_r != LAST_ADDR) begin
                            addr_r  <= addr_r + AW'(1);
                            ra_r    <= addr_r + AW'(1);
                            state_r <= ST_READ;
                        end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            state_r <= ST_CSUM;
`else
                            done_r  <= 1'b1;
                            state_r <= ST_FIN;
`endif
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    // First cycle loads the checksum beat, then it is held until accepted.
                    if (!out_valid_r) begin
                        out_data_r  <= csum_r;
                        out_addr_r  <= {AW{1'b0}};
                        out_last_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_CSUM;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_FIN;
                    end else begin
                        state_r     <= ST_CSUM;
                    end
                end
`endif
                ST_FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    ra_r        <= {AW{1'b0}};
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full dump, back-pressure, ignored start,
// mid-dump reset and back-to-back dumps. Register k holds 0x1000_0000|k, reg0=0.
module tb_regfile_dump;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int NBEATS = NREGS + 1;
`else
    localparam int NBEATS = NREGS;
`endif

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NREGS];

    int n_checks;
    int n_errors;
    int cyc;
    int beat_idx;
    int done_cnt;
    int idle_between;
    int last_acc_cyc;
    int done_cyc;
    int stall_left;
    bit pulse_pending;
    bit hold_start;

    regfile_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ra        (ra),
        .rd        (rd),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    assign rd = regs[ra];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int i);
        int k;
        k = i % NBEATS;
        if (k >= NREGS) return 32'h1000_0000;   // checksum: 31 copies of bit 28, 1..31 XOR to 0
        if (k == 0) return 32'h0000_0000;
        return 32'h1000_0000 | 32'(k);
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int i);
        int k;
        k = i % NBEATS;
        if (k >= NREGS) return 5'd0;
        return AW'(k);
    endfunction

    function automatic logic exp_last(input int i);
        return ((i % NBEATS) == (NBEATS - 1)) ? 1'b1 : 1'b0;
    endfunction

    // One clock: sample 1 time unit after the edge, apply the ready/start
    // policy for the next edge, then score the beat if it will be accepted.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (stall_left > 0 && (stall_left < 3 || (out_valid && out_addr == 5'd5))) begin
            out_ready = 1'b0;
            check_eq("stall_valid", 64'(out_valid), 64'd1);
            check_eq("stall_data", 64'(out_data), 64'h1000_0005);
            check_eq("stall_addr", 64'(out_addr), 64'd5);
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
        if (hold_start) begin
            start = 1'b1;
        end else if (pulse_pending && out_valid && out_addr == 5'd10) begin
            start = 1'b1;
            pulse_pending = 1'b0;
        end else begin
            start = 1'b0;
        end
        if (out_valid) begin
            check_eq("ra_zero_in_send", 64'(ra), 64'd0);
        end else if (busy && !done && (beat_idx % NBEATS) < NREGS) begin
            check_eq("ra_in_read", 64'(ra), 64'(exp_addr(beat_idx)));
        end
        if (out_valid && out_ready) begin
            check_eq("beat_addr", 64'(out_addr), 64'(exp_addr(beat_idx)));
            check_eq("beat_data", 64'(out_data), 64'(exp_data(beat_idx)));
            check_eq("beat_last", 64'(out_last), 64'(exp_last(beat_idx)));
            beat_idx++;
            last_acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (done_cnt == 1 && !busy) idle_between++;
    endtask

    task automatic clear_stats();
        beat_idx      = 0;
        done_cnt      = 0;
        idle_between  = 0;
        last_acc_cyc  = 0;
        done_cyc      = 0;
        stall_left    = 0;
        pulse_pending = 1'b0;
        hold_start    = 1'b0;
    endtask

    // Run until the given number of done pulses, bounded by a cycle budget.
    task automatic run_until_done(input int target, input int budget);
        int t0;
        t0 = cyc;
        while (done_cnt < target && (cyc - t0) < budget) step();
        check_eq("done_reached", 64'(done_cnt), 64'(target));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        clear_stats();
        for (int k = 0; k < NREGS; k++) regs[k] = (k == 0) ? 32'h0 : (32'h1000_0000 | 32'(k));

        // Reset state
        #3;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_ra", 64'(ra), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        check_eq("rst_addr", 64'(out_addr), 64'd0);
        check_eq("rst_last", 64'(out_last), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Full dump with out_ready high, including first-beat latency
        clear_stats();
        start = 1'b1;
        step();
        check_eq("lat_busy", 64'(busy), 64'd1);
        check_eq("lat_valid_read", 64'(out_valid), 64'd0);
        step();
        check_eq("lat_valid_send", 64'(out_valid), 64'd1);
        run_until_done(1, 300);
        check_eq("full_beats", 64'(beat_idx), 64'(NBEATS));
        check_eq("done_after_last", 64'(done_cyc - last_acc_cyc), 64'd1);
        step();
        check_eq("done_one_cycle", 64'(done), 64'd0);
        check_eq("busy_after_fin", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) step();
        check_eq("no_extra_beats", 64'(beat_idx), 64'(NBEATS));

        // Back-pressure on beat 5
        clear_stats();
        stall_left = 3;
        start = 1'b1;
        run_until_done(1, 300);
        check_eq("stall_taken", 64'(stall_left), 64'd0);
        check_eq("stall_beats", 64'(beat_idx), 64'(NBEATS));

        // start pulsed mid-dump must be ignored
        step();
        clear_stats();
        pulse_pending = 1'b1;
        start = 1'b1;
        run_until_done(1, 300);
        for (int i = 0; i < 20; i++) step();
        check_eq("pulse_fired", 64'(pulse_pending), 64'd0);
        check_eq("pulse_one_done", 64'(done_cnt), 64'd1);
        check_eq("pulse_beats", 64'(beat_idx), 64'(NBEATS));

        // Reset during SEND of addr 7
        clear_stats();
        start = 1'b1;
        begin
            int t0;
            t0 = cyc;
            while (!(out_valid && out_addr == 5'd7) && (cyc - t0) < 100) step();
        end
        check_eq("reached_addr7", 64'(out_addr), 64'd7);
        reset_n = 1'b0;
        #1;
        check_eq("abort_valid", 64'(out_valid), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_ra", 64'(ra), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 10; i++) step();
        check_eq("abort_no_beats", 64'(beat_idx), 64'd0);
        check_eq("abort_no_done", 64'(done_cnt), 64'd0);
        start = 1'b1;
        run_until_done(1, 300);
        check_eq("restart_beats", 64'(beat_idx), 64'(NBEATS));

        // start held high: two back-to-back dumps with one IDLE cycle between
        step();
        clear_stats();
        hold_start = 1'b1;
        start = 1'b1;
        run_until_done(2, 600);
        hold_start = 1'b0;
        start = 1'b0;
        check_eq("b2b_idle_cycles", 64'(idle_between), 64'd1);
        check_eq("b2b_beats", 64'(beat_idx), 64'(2 * NBEATS));
        for (int i = 0; i < 5; i++) step();
        check_eq("b2b_stopped", 64'(busy), 64'd0);
        check_eq("b2b_done_count", 64'(done_cnt), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
